// File: rtl/decoder_stage_sequencer.sv
// Shared SRAM port scheduler for the image decompressor.
// Runs the masked processing stages in fixed order (0, 1, 2), hands each one
// exclusive SRAM ownership until its done pulse, separates stages with a
// write-blocked guard gap, and returns the port to the display fetch client
// whenever no stage is running. A per-stage watchdog aborts a hung stage.
module decoder_stage_sequencer #(
  parameter int          ADDR_W     = 18,
  parameter int          DATA_W     = 16,
  parameter int          GAP_CYCLES = 2,
  parameter logic [23:0] TIMEOUT    = 24'd16000000
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic [2:0]            stage_mask,
  output logic [2:0]            stage_enable,
  input  logic [2:0]            stage_done,
  input  logic [3*ADDR_W-1:0]   stage_address,
  input  logic [3*DATA_W-1:0]   stage_write_data,
  input  logic [2:0]            stage_we_n,
  input  logic [ADDR_W-1:0]     display_address,
  output logic [ADDR_W-1:0]     SRAM_address,
  output logic [DATA_W-1:0]     SRAM_write_data,
  output logic                  SRAM_we_n,
  output logic                  busy,
  output logic [1:0]            active_stage,
  output logic                  frame_done,
  output logic                  timeout_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  cur_r;
  logic [2:0]  mask_r;
  logic [3:0]  gap_cnt_r;
  logic [23:0] wdog_r;
  logic [2:0]  stage_enable_r;
  logic        frame_done_r;
  logic        timeout_error_r;
  logic        busy_r;
  logic [1:0]  active_stage_r;

  logic [2:0]  start_pick_s;
  logic [2:0]  gap_pick_s;
  logic        done_hit_s;
  logic        wdog_expired_s;
  logic        gap_last_s;

  // Lowest set mask bit at or above index lo; result is {found, index}.
  function automatic logic [2:0] first_stage(input logic [2:0] mask, input int lo);
    logic [2:0] pick;
    pick = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      if (mask[k] && (k >= lo)) begin
        pick = {1'b1, 2'(k)};
      end
    end
    return pick;
  endfunction

  assign start_pick_s   = first_stage(stage_mask, 0);
  assign gap_pick_s     = first_stage(mask_r, int'(cur_r) + 1);
  assign done_hit_s     = stage_done[cur_r];
  assign wdog_expired_s = (wdog_r == (TIMEOUT - 24'd1));
  assign gap_last_s     = (gap_cnt_r == 4'(GAP_CYCLES - 1));

  // Sequencer FSM: stage order, guard gap, watchdog and all registered status outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r         <= ST_IDLE;
      cur_r           <= 2'd0;
      mask_r          <= 3'b000;
      gap_cnt_r       <= 4'd0;
      wdog_r          <= 24'd0;
      stage_enable_r  <= 3'b000;
      frame_done_r    <= 1'b0;
      timeout_error_r <= 1'b0;
      busy_r          <= 1'b0;
      active_stage_r  <= 2'd3;
    end else begin
      stage_enable_r <= 3'b000;
      frame_done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            timeout_error_r <= 1'b0;
            mask_r          <= stage_mask;
            busy_r          <= 1'b1;
            if (start_pick_s[2]) begin
              state_r        <= ST_RUN;
              cur_r          <= start_pick_s[1:0];
              stage_enable_r <= 3'b001 << start_pick_s[1:0];
              wdog_r         <= 24'd0;
              active_stage_r <= start_pick_s[1:0];
            end else begin
              state_r        <= ST_DONE;
              active_stage_r <= 2'd3;
            end
          end
        end
        ST_RUN: begin
          // A done pulse takes priority over a watchdog expiry in the same cycle.
          if (done_hit_s) begin
            state_r        <= ST_GAP;
            gap_cnt_r      <= 4'd0;
            active_stage_r <= 2'd3;
          end else if (wdog_expired_s) begin
            state_r         <= ST_IDLE;
            timeout_error_r <= 1'b1;
            busy_r          <= 1'b0;
            active_stage_r  <= 2'd3;
          end else begin
            wdog_r <= wdog_r + 24'd1;
          end
        end
        ST_GAP: begin
          if (gap_last_s) begin
            if (gap_pick_s[2]) begin
              state_r        <= ST_RUN;
              cur_r          <= gap_pick_s[1:0];
              stage_enable_r <= 3'b001 << gap_pick_s[1:0];
              wdog_r         <= 24'd0;
              active_stage_r <= gap_pick_s[1:0];
            end else begin
              state_r <= ST_DONE;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          frame_done_r <= 1'b1;
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
        end
        default: begin
          state_r        <= ST_IDLE;
          busy_r         <= 1'b0;
          active_stage_r <= 2'd3;
        end
      endcase
    end
  end

  // SRAM port mux: running stage owns the port, display reads when idle, writes blocked otherwise.
  always_comb begin
    SRAM_address    = {ADDR_W{1'b0}};
    SRAM_write_data = {DATA_W{1'b0}};
    SRAM_we_n       = 1'b1;
    case (state_r)
      ST_RUN: begin
        SRAM_address    = stage_address[int'(cur_r) * ADDR_W +: ADDR_W];
        SRAM_write_data = stage_write_data[int'(cur_r) * DATA_W +: DATA_W];
        SRAM_we_n       = stage_we_n[cur_r];
      end
      ST_IDLE: begin
        SRAM_address = display_address;
      end
      default: begin
        SRAM_address = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign stage_enable  = stage_enable_r;
  assign frame_done    = frame_done_r;
  assign timeout_error = timeout_error_r;
  assign busy          = busy_r;
  assign active_stage  = active_stage_r;

endmodule

// File: tb/tb_decoder_stage_sequencer.sv
// Randomized bench for decoder_stage_sequencer. For every frame a timeline
// model derives, from the mask and each stage's done latency, what every
// output must be on every cycle; the bench then drives that frame (with
// random SRAM traffic, spurious done pulses and spurious starts) and compares.
module tb_decoder_stage_sequencer;

  localparam int          ADDR_W = 18;
  localparam int          DATA_W = 16;
  localparam int          GAP    = 2;
  localparam logic [23:0] TMO    = 24'd20;
  localparam int          MAXC   = 128;
  localparam int          NEVER  = 999;

  logic                Clock = 1'b0;
  logic                Resetn = 1'b0;
  logic                start = 1'b0;
  logic [2:0]          stage_mask = 3'b000;
  logic [2:0]          stage_enable;
  logic [2:0]          stage_done = 3'b000;
  logic [3*ADDR_W-1:0] stage_address = '0;
  logic [3*DATA_W-1:0] stage_write_data = '0;
  logic [2:0]          stage_we_n = 3'b111;
  logic [ADDR_W-1:0]   display_address = 18'h01234;
  logic [ADDR_W-1:0]   SRAM_address;
  logic [DATA_W-1:0]   SRAM_write_data;
  logic                SRAM_we_n;
  logic                busy;
  logic [1:0]          active_stage;
  logic                frame_done;
  logic                timeout_error;

  decoder_stage_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .stage_mask(stage_mask),
    .stage_enable(stage_enable), .stage_done(stage_done),
    .stage_address(stage_address), .stage_write_data(stage_write_data),
    .stage_we_n(stage_we_n), .display_address(display_address),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .busy(busy), .active_stage(active_stage),
    .frame_done(frame_done), .timeout_error(timeout_error)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit te_model = 1'b0;

  // Expected per-cycle timeline of one frame; mode 0 idle, 1 run, 2 gap/done.
  logic [2:0] m_en   [MAXC];
  logic       m_busy [MAXC];
  logic [1:0] m_act  [MAXC];
  logic       m_fd   [MAXC];
  logic       m_te   [MAXC];
  logic [1:0] m_mode [MAXC];
  logic [2:0] m_done [MAXC];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic randomize_traffic();
    logic [63:0] r;
    r = {$urandom, $urandom};
    stage_address = r[3*ADDR_W-1:0];
    r = {$urandom, $urandom};
    stage_write_data = r[3*DATA_W-1:0];
    stage_we_n = 3'($urandom);
    display_address = ADDR_W'($urandom);
  endtask

  task automatic check_sram(input logic [1:0] mode, input logic [1:0] owner);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              ew;
    if (mode == 2'd1) begin
      ea = stage_address[int'(owner) * ADDR_W +: ADDR_W];
      ed = stage_write_data[int'(owner) * DATA_W +: DATA_W];
      ew = stage_we_n[owner];
    end else if (mode == 2'd0) begin
      ea = display_address;
      ed = '0;
      ew = 1'b1;
    end else begin
      ea = '0;
      ed = '0;
      ew = 1'b1;
    end
    check_val("sram_addr", 32'(SRAM_address), 32'(ea));
    check_val("sram_data", 32'(SRAM_write_data), 32'(ed));
    check_val("sram_we_n", 32'(SRAM_we_n), 32'(ew));
  endtask

  // Idle cycles between frames; done pulses here must have no effect.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      stage_mask = 3'($urandom);
      stage_done = 3'($urandom);
      randomize_traffic();
      #1;
      check_val("idle_en", 32'(stage_enable), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_act", 32'(active_stage), 32'd3);
      check_val("idle_fd", 32'(frame_done), 32'd0);
      check_val("idle_te", 32'(timeout_error), 32'(te_model));
      check_sram(2'd0, 2'd0);
      @(posedge Clock);
      #1;
      cyc++;
    end
  endtask

  // One frame; lat[k] is cycles from stage k's enable to its done (NEVER = hangs).
  task automatic run_frame(input logic [2:0] mask, input int lat0, input int lat1, input int lat2);
    int lat[3];
    int pos;
    int len;
    int tmo_at;
    bit tmo;
    logic [2:0] spur;
    lat[0] = lat0;
    lat[1] = lat1;
    lat[2] = lat2;
    for (int c = 0; c < MAXC; c++) begin
      m_en[c] = 3'b000; m_busy[c] = 1'b0; m_act[c] = 2'd3; m_fd[c] = 1'b0;
      m_te[c] = 1'b0; m_mode[c] = 2'd0; m_done[c] = 3'b000;
    end
    m_te[0] = te_model;
    pos = 1;
    tmo = 1'b0;
    tmo_at = 0;
    for (int k = 0; k < 3; k++) begin
      if (mask[k] && !tmo) begin
        m_en[pos][k] = 1'b1;
        if (lat[k] <= int'(TMO) - 1) begin
          for (int c = pos; c <= pos + lat[k]; c++) begin
            m_busy[c] = 1'b1; m_act[c] = 2'(k); m_mode[c] = 2'd1;
          end
          m_done[pos + lat[k]][k] = 1'b1;
          for (int c = pos + lat[k] + 1; c <= pos + lat[k] + GAP; c++) begin
            m_busy[c] = 1'b1; m_mode[c] = 2'd2;
          end
          pos = pos + lat[k] + 1 + GAP;
        end else begin
          for (int c = pos; c < pos + int'(TMO); c++) begin
            m_busy[c] = 1'b1; m_act[c] = 2'(k); m_mode[c] = 2'd1;
          end
          tmo = 1'b1;
          tmo_at = pos + int'(TMO);
        end
      end
    end
    if (tmo) begin
      len = tmo_at + 1;
      for (int c = tmo_at; c < len; c++) m_te[c] = 1'b1;
    end else begin
      m_busy[pos] = 1'b1;
      m_mode[pos] = 2'd2;
      m_fd[pos + 1] = 1'b1;
      len = pos + 2;
    end
    te_model = tmo;

    for (int c = 0; c < len; c++) begin
      spur = 3'($urandom) & 3'($urandom);
      if (m_mode[c] == 2'd1) spur = spur & ~(3'b001 << m_act[c]);
      start = (c == 0) ? 1'b1 : (m_busy[c] && ($urandom_range(0, 3) == 0));
      stage_mask = (c == 0) ? mask : 3'($urandom);
      stage_done = m_done[c] | spur;
      randomize_traffic();
      #1;
      check_val("enable", 32'(stage_enable), 32'(m_en[c]));
      check_val("busy", 32'(busy), 32'(m_busy[c]));
      check_val("active", 32'(active_stage), 32'(m_act[c]));
      check_val("frame_done", 32'(frame_done), 32'(m_fd[c]));
      check_val("timeout_err", 32'(timeout_error), 32'(m_te[c]));
      check_sram(m_mode[c], m_act[c]);
      @(posedge Clock);
      #1;
      cyc++;
    end
    start = 1'b0;
    stage_done = 3'b000;
  endtask

  initial begin
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    display_address = 18'h01234;
    #1;
    check_val("rst_addr", 32'(SRAM_address), 32'h01234);
    check_val("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_act", 32'(active_stage), 32'd3);
    check_val("rst_te", 32'(timeout_error), 32'd0);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    idle_cycles(3);

    run_frame(3'b011, 10, 5, 0);
    idle_cycles(2);
    run_frame(3'b100, 0, 0, 4);
    idle_cycles(1);
    run_frame(3'b000, 0, 0, 0);
    idle_cycles(1);
    run_frame(3'b001, NEVER, 0, 0);
    idle_cycles(2);
    run_frame(3'b111, 0, int'(TMO) - 1, 3);
    run_frame(3'b110, 2, NEVER, 1);
    idle_cycles(1);

    for (int f = 0; f < 40; f++) begin
      run_frame(3'($urandom),
                ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 14)),
                ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 14)),
                ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 14)));
      idle_cycles(int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while stage 1 is running and writing.
    start = 1'b1;
    stage_mask = 3'b010;
    stage_done = 3'b000;
    @(posedge Clock);
    #1;
    start = 1'b0;
    stage_we_n = 3'b101;
    repeat (3) @(posedge Clock);
    #1;
    check_val("pre_rst_we_n", 32'(SRAM_we_n), 32'd0);
    check_val("pre_rst_act", 32'(active_stage), 32'd1);
    Resetn = 1'b0;
    #1;
    check_val("arst_we_n", 32'(SRAM_we_n), 32'd1);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_act", 32'(active_stage), 32'd3);
    check_val("arst_en", 32'(stage_enable), 32'd0);
    check_val("arst_addr", 32'(SRAM_address), 32'(display_address));
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    te_model = 1'b0;
    idle_cycles(3);
    run_frame(3'b101, 4, 0, 6);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_stage_sequencer.md
Name: decoder_stage_sequencer

Overview:
Top-level scheduler for the image decompressor's single shared SRAM port. On a start pulse it runs up to three processing stages in fixed order: stage 0 is the IDCT milestone, stage 1 the upsample/colour-space milestone, stage 2 a spare. For each stage it issues an enable pulse, gives that stage exclusive SRAM ownership, waits for its done pulse, and inserts a guard gap before the next stage. When no stage is running, the SRAM port belongs to the read-only display fetch client.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
GAP_CYCLES, 2, idle cycles between stages with writes blocked (range 1..15)
TIMEOUT, 24'd16000000, max cycles a stage may run before it is aborted

Ports:
Clock  in  1  system clock
Resetn  in  1  async active-low reset
start  in  1  1-cycle pulse requesting one frame decode
stage_mask  in  3  bit k=1 runs stage k; sampled on the accepted start
stage_enable  out  3  one-hot 1-cycle start pulse to stage k
stage_done  in  3  1-cycle completion pulse from stage k
stage_address  in  3*ADDR_W  packed, stage k at bits [k*ADDR_W +: ADDR_W]
stage_write_data  in  3*DATA_W  packed, same layout
stage_we_n  in  3  per-stage active-low write enable
display_address  in  ADDR_W  display fetch address (read-only client)
SRAM_address  out  ADDR_W  muxed SRAM address
SRAM_write_data  out  DATA_W  muxed SRAM write data
SRAM_we_n  out  1  muxed active-low write enable
busy  out  1  high in any state except IDLE
active_stage  out  2  owning stage 0..2; 3 when none owns the port
frame_done  out  1  1-cycle pulse when all masked stages have completed
timeout_error  out  1  sticky error; cleared by the next accepted start

Behaviour:
- Clock is Clock; reset is Resetn, asynchronous, active-low.
- Reset values and effect:
  - State IDLE; stage_enable=0, frame_done=0, timeout_error=0, busy=0, active_stage=3.
  - SRAM outputs follow the IDLE mux: address=display_address, write_data=0, we_n=1.
- Reset mid-frame: all outputs take their reset values immediately; no frame_done is issued.
- States: IDLE, RUN, GAP, DONE. Registers: stage pointer cur (0..2), latched mask, gap counter, 24-bit watchdog.
- SRAM mux (combinational from registered state):
  - RUN: forwards stage_address/write_data/we_n of stage cur.
  - IDLE: display_address, write_data 0, we_n=1.
  - GAP and DONE: address 0, write_data 0, we_n=1.
- IDLE: start sampled at cycle t.
  - If mask!=0: at t+1 state=RUN, cur=lowest set mask bit, stage_enable[cur]=1 for cycle t+1 only.
  - If mask==0: state=DONE at t+1.
  - A start accepted here also clears timeout_error.
- start outside IDLE is ignored.
- RUN:
  - Watchdog clears on RUN entry and increments every cycle.
  - stage_done[cur] at cycle d leads to GAP at d+1.
  - stage_done from any stage other than cur is ignored.
  - Watchdog reaching TIMEOUT-1 with no done: timeout_error=1, state=IDLE, no frame_done.
  - done and timeout in the same cycle: done wins.
  - done in the same cycle as the enable pulse is accepted.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - Then RUN for the next higher set mask bit, with its enable pulse on the RUN entry cycle.
  - If no higher bit is set, goes to DONE.
- DONE: one cycle; frame_done=1; then IDLE.
- active_stage=cur in RUN, 3 otherwise. busy=1 in RUN/GAP/DONE.
- Stages are never reordered or repeated within a frame.

Test Plan:
- Reset, then idle: SRAM_address tracks display_address=18'h1234; we_n=1; busy=0; active_stage=3.
- mask=3'b011, start at t0; stage 0 done after 10 cycles, stage 1 done after 5:
  - enable[0] at t0+1; GAP for 2 cycles; enable[1] one cycle after the GAP ends.
  - frame_done is one cycle after the cycle following the last GAP.
  - During RUN, SRAM outputs equal the owner's stage_address/write_data/we_n; spurious stage_done[2] is ignored.
- mask=3'b100: only enable[2] fires. mask=3'b000: frame_done at t0+2 with no enables.
- TIMEOUT overridden to 20, stage 0 never done:
  - timeout_error=1 at RUN cycle 20; state returns to IDLE with no frame_done.
  - The next start clears timeout_error.
- start re-pulsed during RUN and GAP: no effect on state, cur or enables.
- Resetn pulled low during stage 1 RUN with stage_we_n[1]=0: SRAM_we_n=1 and busy=0 asynchronously, before the next clock edge.
